apb_req_arbiter: RTL and testbench

Two-port APB master that shares the timer's APB slave port between two requesters (configuration sequencer on port 0, test/diagnostic sequencer on port 1). Each requester issues single read or write commands. The block arbitrates round-robin and drives compliant APB setup/access phases on the `pclkg` domain. It waits on `pready`, applies a programmable timeout, and returns read data and error status to the granted requester.

---
 rtl/apb_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, pready wait
// with optional timeout, and a registered one-cycle response back to the granted requester.
module apb_req_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        pclkg,
    input  logic        preset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [19:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        timeout_pulse,
    output logic        busy,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [9:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // The counter only ever has to hold TIMEOUT-1: the cycle that would reach TIMEOUT exits.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           psel_q, psel_d;
    logic           penable_q, penable_d;
    logic           pwrite_q, pwrite_d;
    logic [9:0]     paddr_q, paddr_d;
    logic [31:0]    pwdata_q, pwdata_d;
    logic [1:0]     resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;
    logic           timeout_q, timeout_d;

    logic [9:0]     addr_slice  [2];
    logic [31:0]    wdata_slice [2];
    logic           any_valid;
    logic           gnt_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign addr_slice[gi]  = req_addr[10*gi +: 10];
            assign wdata_slice[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    // On a tie the requester that was not granted last wins; otherwise the lone valid one.
    assign any_valid = |req_valid;
    assign gnt_sel   = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        timeout_d    = 1'b0;
        req_ready    = 2'b00;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready = gnt_sel ? 2'b10 : 2'b01;
                    state_d   = SETUP;
                    last_d    = gnt_sel;
                    gnt_d     = gnt_sel;
                    pwrite_d  = req_write[gnt_sel];
                    paddr_d   = addr_slice[gnt_sel];
                    pwdata_d  = wdata_slice[gnt_sel];
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                // pready wins over a timeout landing on the same cycle.
                if (pready) begin
                    state_d      = IDLE;
                    resp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    resp_rdata_d = pwrite_q ? 32'h0 : prdata;
                    resp_err_d   = pslverr;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = IDLE;
                    resp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    resp_err_d   = 1'b1;
                    timeout_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (preset) begin
            req_ready = 2'b00;
        end
    end

    assign psel_d    = (state_d != IDLE);
    assign penable_d = (state_d == ACCESS);

    always_ff @(posedge pclkg) begin
        if (preset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign psel          = psel_q;
    assign penable       = penable_q;
    assign busy          = psel_q;
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios with literal expectations, then random
// requesters and slave, all checked every cycle against a transaction-level model.
module tb_apb_req_arbiter;

    localparam int TO = 4;

    logic        pclkg = 1'b0;
    logic        preset;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err, timeout_pulse, busy, psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    always #5 pclkg = ~pclkg;

    apb_req_arbiter #(.TIMEOUT(TO)) dut (
        .pclkg(pclkg), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .timeout_pulse(timeout_pulse), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one transfer in flight, aged in cycles since its accept.
    bit          m_active, m_owner, m_write, m_last;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    int          m_age, m_waits;
    logic [1:0]  m_rv, m_g;
    logic [31:0] m_rdata;
    bit          m_err, m_to;
    logic [1:0]  obs_ready, obs_rv;

    function automatic logic [1:0] exp_ready();
        if (preset || m_active || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    task automatic check_all();
        chk("req_ready", req_ready, exp_ready());
        chk("psel", psel, m_active);
        chk("penable", penable, m_active && m_age >= 2);
        chk("busy", busy, m_active);
        chk("pwrite", pwrite, m_write);
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("resp_valid", resp_valid, m_rv);
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", resp_err, m_err);
        chk("timeout_pulse", timeout_pulse, m_to);
    endtask

    task automatic model_step();
        int o;
        m_g = exp_ready();
        if (preset) begin
            m_active = 0; m_last = 1; m_write = 0; m_addr = '0; m_wdata = '0;
            m_rv = '0; m_rdata = '0; m_err = 0; m_to = 0;
            return;
        end
        m_rv = '0; m_rdata = '0; m_err = 0; m_to = 0;
        if (m_active) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (pready) begin
                m_rv = m_owner ? 2'b10 : 2'b01;
                m_rdata = m_write ? 32'h0 : prdata;
                m_err = pslverr;
                m_active = 0;
            end else begin
                m_waits++;
                m_age++;
                if (m_waits == TO) begin
                    m_rv = m_owner ? 2'b10 : 2'b01;
                    m_err = 1; m_to = 1; m_active = 0;
                end
            end
        end else if (m_g != 2'b00) begin
            o = m_g[1] ? 1 : 0;
            m_owner = m_g[1];
            m_write = req_write[o];
            m_addr  = req_addr[10*o +: 10];
            m_wdata = req_wdata[32*o +: 32];
            m_last  = m_g[1];
            m_active = 1; m_age = 1; m_waits = 0;
        end
    endtask

    task automatic cyc();
        @(negedge pclkg);
        check_all();
        obs_ready = req_ready;
        obs_rv    = resp_valid;
        if (resp_valid != 2'b00)
            $display("xfer req%0d rdata=%h err=%0d to=%0d t=%0t",
                     resp_valid[1], resp_rdata, resp_err, timeout_pulse, $time);
        model_step();
        @(posedge pclkg);
        #1;
    endtask

    task automatic set_cmd(int r, logic wr, logic [9:0] a, logic [31:0] d);
        req_write[r] = wr;
        req_addr[10*r +: 10] = a;
        req_wdata[32*r +: 32] = d;
    endtask

    logic [1:0] grants[$];
    int         resp_cyc[$];
    int         acc;

    initial begin
        preset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        prdata = 0; pready = 0; pslverr = 0;
        model_step();
        @(posedge pclkg); #1;
        cyc(); cyc();
        chk("rst_psel", psel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_paddr", paddr, 0);
        preset = 0;

        // Single zero-wait write
        set_cmd(0, 1, 10'h004, 32'hDEADBEEF);
        req_valid = 2'b01;
        #1 chk("t1_ready", req_ready, 2'b01);
        cyc();
        req_valid = 0;
        chk("t1_setup", {psel, penable}, 2'b10);
        cyc();
        chk("t1_access", {psel, penable}, 2'b11);
        chk("t1_paddr", paddr, 10'h004);
        chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        pready = 1;
        cyc();
        pready = 0;
        chk("t1_resp_valid", resp_valid, 2'b01);
        chk("t1_resp_err", resp_err, 0);

        // Read with 3 wait states
        set_cmd(0, 0, 10'h010, 32'h0);
        req_valid = 2'b01;
        cyc();
        req_valid = 0;
        cyc();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (penable) acc++;
            if (i == 3) begin pready = 1; prdata = 32'h12345678; end
            cyc();
        end
        pready = 0; prdata = 32'h0;
        chk("t2_access_cycles", acc, 4);
        chk("t2_resp_valid", resp_valid, 2'b01);
        chk("t2_rdata", resp_rdata, 32'h12345678);

        // Slave error on a req1 write
        set_cmd(1, 1, 10'h3FF, 32'hCAFEF00D);
        req_valid = 2'b10;
        cyc();
        req_valid = 0;
        cyc();
        pready = 1; pslverr = 1;
        cyc();
        pready = 0; pslverr = 0;
        chk("t3_resp_valid", resp_valid, 2'b10);
        chk("t3_resp_err", resp_err, 1);

        // Timeout with pready stuck low, then a normal transfer
        set_cmd(0, 0, 10'h020, 32'h0);
        prdata = 32'hFFFFFFFF;
        req_valid = 2'b01;
        cyc();
        req_valid = 0;
        acc = 0;
        for (int i = 0; i < 12 && !timeout_pulse; i++) begin
            if (penable) acc++;
            cyc();
        end
        chk("t4_access_cycles", acc, TO);
        chk("t4_timeout_pulse", timeout_pulse, 1);
        chk("t4_resp_err", resp_err, 1);
        chk("t4_rdata", resp_rdata, 32'h0);
        chk("t4_resp_valid", resp_valid, 2'b01);
        set_cmd(1, 0, 10'h155, 32'h0);
        req_valid = 2'b10;
        cyc();
        req_valid = 0;
        cyc();
        pready = 1; prdata = 32'hA5A5A5A5;
        cyc();
        pready = 0;
        chk("t4b_resp_valid", resp_valid, 2'b10);
        chk("t4b_rdata", resp_rdata, 32'hA5A5A5A5);
        chk("t4b_err", resp_err, 0);

        // Contention from reset
        preset = 1;
        set_cmd(0, 1, 10'h001, 32'h11111111);
        set_cmd(1, 0, 10'h002, 32'h22222222);
        req_valid = 2'b11;
        cyc(); cyc();
        preset = 0; pready = 1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (obs_ready != 2'b00) grants.push_back(obs_ready);
            if (obs_rv != 2'b00) resp_cyc.push_back(i);
        end
        req_valid = 0;
        for (int i = 0; i < 4; i++) cyc();
        chk("t5_grant_count", grants.size() >= 4, 1);
        chk("t5_resp_count", resp_cyc.size() >= 4, 1);
        if (grants.size() >= 4) begin
            chk("t5_grant0", grants[0], 2'b01);
            chk("t5_grant1", grants[1], 2'b10);
            chk("t5_grant2", grants[2], 2'b01);
            chk("t5_grant3", grants[3], 2'b10);
        end
        if (resp_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) chk("t5_resp_spacing", resp_cyc[i] - resp_cyc[i-1], 3);
        end
        pready = 0;

        // Reset in the middle of a req1 read
        set_cmd(1, 0, 10'h2AA, 32'h0);
        req_valid = 2'b10;
        cyc();
        req_valid = 0;
        cyc(); cyc();
        chk("t6_in_access", penable, 1);
        preset = 1;
        cyc();
        preset = 0;
        chk("t6_psel", psel, 0);
        chk("t6_penable", penable, 0);
        chk("t6_busy", busy, 0);
        chk("t6_paddr", paddr, 0);
        chk("t6_resp_valid", resp_valid, 0);
        cyc();
        chk("t6_no_resp", resp_valid, 0);
        req_valid = 2'b11;
        #1 chk("t6_tie_after_reset", req_ready, 2'b01);
        cyc();
        req_valid = 2'b10;
        cyc();
        pready = 1;
        cyc();
        chk("t6_r0_resp", resp_valid, 2'b01);
        cyc();
        req_valid = 0;
        cyc(); cyc();
        chk("t6_r1_resp", resp_valid, 2'b10);
        pready = 0;

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (req_valid[r] && m_g[r]) begin
                    req_valid[r] = ($urandom_range(0, 2) != 0);
                    if (req_valid[r]) set_cmd(r, 1'($urandom), 10'($urandom), $urandom);
                end else if (req_valid[r]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[r] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_cmd(r, 1'($urandom), 10'($urandom), $urandom);
                    req_valid[r] = 1;
                end
            end
            pready  = ((c / 250) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            pslverr = ($urandom_range(0, 7) == 0);
            prdata  = $urandom;
            preset  = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
